// File: rtl/multi_ch_idle_clk_gating_pkg.sv
// Shared types and default constants for the multi-channel idle clock gate.
// The channel state encoding lives here so that the top and the channel FSM agree on it.
package multi_ch_idle_clk_gating_pkg;

   typedef enum logic [1:0] {
      CG_OFF  = 2'd0,
      CG_ON   = 2'd1,
      CG_IDLE = 2'd2
   } cgState_e;

   localparam int SYNC_STAGE_DEF = 2;
   localparam int IDLE_CNT_W_DEF = 8;

endpackage

// File: rtl/BB_clk_gating.sv
// Latch-based clock gate. The enable passes through only while clk_i is low,
// so the gated clock never shows a glitch or a truncated pulse.
module BB_clk_gating #(
   parameter logic RST_VAL = 1'b0
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic en_i,
   input  logic test_en_i,
   output logic gclk_o
);

   logic enLatch;

   // Reset forces the gate to its reset state at once, but test_en_i still keeps a bypassed clock running.
   always_latch begin
      if (!rst_ni) begin
         enLatch = RST_VAL | test_en_i;
      end else if (!clk_i) begin
         enLatch = en_i | test_en_i;
      end
   end

   assign gclk_o = clk_i & enLatch;

endmodule

// File: rtl/BB_signal_sync.sv
// Multi-bit flop-chain synchroniser; every bit is treated as an independent level signal.
// The output is the input delayed through SYNC_STAGE flops clocked by clk_i.
module BB_signal_sync #(
   parameter int   DW         = 1,
   parameter int   SYNC_STAGE = 2,
   parameter logic RST_VAL    = 1'b0
) (
   input  logic          clk_i,
   input  logic          rst_ni,
   input  logic [DW-1:0] data_i,
   output logic [DW-1:0] data_o
);

   logic [SYNC_STAGE-1:0][DW-1:0] sync_q;

   // Stage 0 samples the asynchronous input; the last stage is the synchronised output.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sync_q <= {(SYNC_STAGE*DW){RST_VAL}};
      end else begin
         sync_q <= {sync_q[SYNC_STAGE-2:0], data_i};
      end
   end

   assign data_o = sync_q[SYNC_STAGE-1];

endmodule

// File: rtl/multi_ch_idle_clk_gating_fsm.sv
// One gated-clock channel: OFF/ON/IDLE state machine with an idle hold-off counter,
// a registered gate enable and a registered clock-on status.
module clk_gate_ch_fsm
   import multi_ch_idle_clk_gating_pkg::*;
#(
   parameter int   IDLE_CNT_W = IDLE_CNT_W_DEF,
   parameter logic RST_VAL    = 1'b0
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  active_i,
   input  logic                  bypass_i,
   input  logic [IDLE_CNT_W-1:0] idle_thresh_i,
   output logic                  en_o,
   output logic                  clk_on_o
);

   cgState_e              state_q, state_d;
   logic [IDLE_CNT_W-1:0] idleCnt_q, idleCnt_d;
   logic                  en_q;
   logic                  clkOn_q;
   logic                  nextEn;

   // The threshold is only sampled on the ON->IDLE step, so changing it never disturbs a running count.
   always_comb begin
      state_d   = state_q;
      idleCnt_d = idleCnt_q;
      unique case (state_q)
         CG_OFF: begin
            if (active_i) state_d = CG_ON;
         end
         CG_ON: begin
            if (!active_i) begin
               if (idle_thresh_i == '0) begin
                  state_d = CG_OFF;
               end else begin
                  state_d   = CG_IDLE;
                  idleCnt_d = idle_thresh_i - IDLE_CNT_W'(1);
               end
            end
         end
         CG_IDLE: begin
            if (active_i) begin
               state_d   = CG_ON;
               idleCnt_d = '0;
            end else if (idleCnt_q == '0) begin
               state_d = CG_OFF;
            end else begin
               idleCnt_d = idleCnt_q - IDLE_CNT_W'(1);
            end
         end
         default: state_d = CG_OFF;
      endcase
   end

   assign nextEn = (state_d != CG_OFF);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q   <= RST_VAL ? CG_ON : CG_OFF;
         idleCnt_q <= '0;
         en_q      <= RST_VAL;
         clkOn_q   <= RST_VAL;
      end else begin
         state_q   <= state_d;
         idleCnt_q <= idleCnt_d;
         en_q      <= nextEn;
         clkOn_q   <= nextEn | bypass_i;
      end
   end

   // While reset is held a bypassed channel still has a running clock, so report it as on.
   assign en_o     = en_q;
   assign clk_on_o = clkOn_q | (bypass_i & ~rst_ni);

endmodule

// File: rtl/multi_ch_idle_clk_gating.sv
// Multi-channel clock gate controller: per-channel synchronised activity requests
// drive independent idle-hysteresis FSMs, each gating its own copy of raw_clk.
module multi_ch_idle_clk_gating
   import multi_ch_idle_clk_gating_pkg::*;
#(
   parameter int   CH_NUM     = 4,
   parameter int   SYNC_STAGE = SYNC_STAGE_DEF,
   parameter int   IDLE_CNT_W = IDLE_CNT_W_DEF,
   parameter logic RST_VAL    = 1'b0
) (
   input  logic                  raw_clk,
   input  logic                  rst_n,
   input  logic [CH_NUM-1:0]     active,
   input  logic [CH_NUM-1:0]     bypass,
   input  logic [IDLE_CNT_W-1:0] idle_thresh,
   output logic [CH_NUM-1:0]     gen_clk,
   output logic [CH_NUM-1:0]     clk_on
);

   logic [CH_NUM-1:0] syncActive;
   logic [CH_NUM-1:0] chEn;

   BB_signal_sync #(
      .DW         (CH_NUM),
      .SYNC_STAGE (SYNC_STAGE),
      .RST_VAL    (RST_VAL)
   ) uActiveSync (
      .clk_i  (raw_clk),
      .rst_ni (rst_n),
      .data_i (active),
      .data_o (syncActive)
   );

   for (genvar ch = 0; ch < CH_NUM; ch++) begin : gChannel
      clk_gate_ch_fsm #(
         .IDLE_CNT_W (IDLE_CNT_W),
         .RST_VAL    (RST_VAL)
      ) uFsm (
         .clk_i         (raw_clk),
         .rst_ni        (rst_n),
         .active_i      (syncActive[ch]),
         .bypass_i      (bypass[ch]),
         .idle_thresh_i (idle_thresh),
         .en_o          (chEn[ch]),
         .clk_on_o      (clk_on[ch])
      );

      BB_clk_gating #(
         .RST_VAL (RST_VAL)
      ) uGate (
         .clk_i     (raw_clk),
         .rst_ni    (rst_n),
         .en_i      (chEn[ch]),
         .test_en_i (bypass[ch]),
         .gclk_o    (gen_clk[ch])
      );
   end

endmodule
